// File: rtl/mul_div_unit.sv
// Iterative signed 16-bit multiply/divide unit: one shift-add or restoring-divide step per cycle,
// result delivered as a single-cycle register-file write.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [3:0]       dst_in_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_addr_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             dz_o
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [1:0] OP_MULL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [3:0]           wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                 dz_q, dz_d;

  logic                 accept;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_sub;
  logic                 div_ge;
  logic                 neg;
  logic                 div_zero;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s, result;

  // Two's-complement magnitude; the most negative value maps onto itself and is read as unsigned.
  assign mag_a = opa_q[WIDTH-1] ? (~opa_q + WIDTH'(1)) : opa_q;
  assign mag_b = opb_q[WIDTH-1] ? (~opb_q + WIDTH'(1)) : opb_q;

  // Multiply step: conditionally add multiplicand into the high half, then shift right.
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mb_q} : '0);

  // Divide step: shift next dividend bit into the 17-bit partial remainder, trial-subtract.
  assign div_shift = {rem_q, p_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mb_q};
  assign div_sub   = div_shift[WIDTH-1:0] - mb_q;

  assign neg      = sa_q ^ sb_q;
  assign div_zero = op_q[1] && (opb_q == '0);
  assign prod_s   = neg ? (~p_q + (2*WIDTH)'(1)) : p_q;
  assign quo_s    = neg ? (~p_q[WIDTH-1:0] + WIDTH'(1)) : p_q[WIDTH-1:0];
  assign rem_s    = sa_q ? (~rem_q + WIDTH'(1)) : rem_q;

  always_comb begin
    result = '0;
    case (op_q)
      OP_MULL: result = prod_s[WIDTH-1:0];
      OP_MULH: result = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV:  result = div_zero ? '1 : quo_s;
      default: result = div_zero ? opa_q : rem_s;
    endcase
  end

  assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    mb_d      = mb_q;
    p_d       = p_q;
    rem_d     = rem_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    dz_d      = dz_q;

    case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: begin
        sa_d    = opa_q[WIDTH-1];
        sb_d    = opb_q[WIDTH-1];
        mb_d    = mag_b;
        p_d     = {{WIDTH{1'b0}}, mag_a};
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (!op_q[1]) begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end else begin
          rem_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
          p_d   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-2:0], div_ge};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        wb_data_d = result;
        dz_d      = div_zero;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = accept ? S_PREP : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept && !abort_i) begin
      op_d      = op_i;
      opa_d     = opa_i;
      opb_d     = opb_i;
      wb_addr_d = dst_in_i;
      dz_d      = 1'b0;
    end

    // A flush cancels the op in flight and leaves the visible write-back state untouched.
    if (abort_i) begin
      state_d   = S_IDLE;
      wb_data_d = wb_data_q;
      dz_d      = dz_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      mb_q      <= '0;
      p_q       <= '0;
      rem_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      mb_q      <= mb_d;
      p_q       <= p_d;
      rem_q     <= rem_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      dz_q      <= dz_d;
    end
  end

  assign busy_o    = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o    = (state_q == S_DONE);
  assign wb_we_o   = done_o && (wb_addr_q != 4'd0);
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign dz_o      = dz_q;

endmodule
